mips_reg_file: RTL and testbench

- Architectural register file of the 16-bit MIPS datapath, one stage upstream of the 4:1 ALU-operand select mux.
- Its two read ports supply the register operands that the mux chooses between, alongside the immediate and forwarded values.
- Holds 8 x 16-bit registers, with one synchronous write port and two combinational read ports.
- R0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.

---
 rtl/mips_reg_file_pkg.sv | 37 +++
 rtl/mips_reg_read_port.sv | 33 +++
 rtl/mips_reg_file.sv | 79 +++++++
 tb/tb_mips_reg_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_reg_file_pkg.sv
// Shared definitions for the 16-bit MIPS register file and the ALU operand select path.
// Register geometry, the hardwired zero index, and the 4:1 operand-mux select encoding.
package mips_reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 3'd0;

  // Operand select driven by the control unit into the ALU operand mux.
  typedef enum logic [1:0] {
    OPSEL_REG     = 2'd0,
    OPSEL_IMM     = 2'd1,
    OPSEL_FWD_EX  = 2'd2,
    OPSEL_FWD_MEM = 2'd3
  } opsel_e;

  function automatic logic [DATA_W-1:0] opsel_mux(
    input opsel_e            sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] imm_val,
    input logic [DATA_W-1:0] fwd_ex_val,
    input logic [DATA_W-1:0] fwd_mem_val
  );
    logic [DATA_W-1:0] res;
    case (sel)
      OPSEL_REG:     res = reg_val;
      OPSEL_IMM:     res = imm_val;
      OPSEL_FWD_EX:  res = fwd_ex_val;
      OPSEL_FWD_MEM: res = fwd_mem_val;
      default:       res = reg_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_reg_read_port.sv
// One combinational read port: address decode, R0 override and, when REGFILE_BYPASS_EN
// is defined, the same-cycle write-to-read bypass compare.
module mips_reg_read_port #(
  parameter int DATA_W = mips_reg_file_pkg::DATA_W,
  parameter int ADDR_W = mips_reg_file_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
`endif
  output logic [DATA_W-1:0] rdata
);
  import mips_reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
    if (byp_en && (byp_addr == raddr)) begin
      rdata = byp_data;
    end
`endif
    // R0 wins over everything, including a bypass aimed at index 0.
    if (raddr == ZERO_IDX) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// 8 x 16-bit architectural register file: one synchronous write port, two combinational
// read ports, R0 hardwired to zero. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module mips_reg_file #(
  parameter int DATA_W = mips_reg_file_pkg::DATA_W,
  parameter int ADDR_W = mips_reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import mips_reg_file_pkg::*;

  localparam int                NUM_REGS_L = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(ZERO_REG);

  logic              wr_en;
  logic [DATA_W-1:0] regs_q    [1:NUM_REGS_L-1];
  logic [DATA_W-1:0] regs_view [NUM_REGS_L];

  assign wr_en = we && (waddr != ZERO_IDX);

  // R0 has no storage; only R1..R7 are flops.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS_L; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wr_en && (waddr == ADDR_W'(i))) begin
        regs_q[i] <= wdata;
      end
    end
  end

  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NUM_REGS_L; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = wr_en && !rst;
`endif

  mips_reg_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd1 (
    .raddr    (raddr1),
    .regs     (regs_view),
`ifdef REGFILE_BYPASS_EN
    .byp_en   (byp_en),
    .byp_addr (waddr),
    .byp_data (wdata),
`endif
    .rdata    (rdata1)
  );

  mips_reg_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rd2 (
    .raddr    (raddr2),
    .regs     (regs_view),
`ifdef REGFILE_BYPASS_EN
    .byp_en   (byp_en),
    .byp_addr (waddr),
    .byp_data (wdata),
`endif
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file against an array model of the register rules;
// expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];

  mips_reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  // Expected read value given the stored model and the inputs currently applied.
  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  // Commit the applied inputs at the next rising edge, then return on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (we && waddr != 3'd0) begin
      model[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
  endtask

  task automatic test_reset();
    logic [2:0] a;
    rst = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0; raddr1 = 3'd0; raddr2 = 3'd0;
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      a = 3'(i); raddr1 = a; raddr2 = 3'(7 - i); #1;
      checks++;
      if (rdata1 !== 16'h0000) begin errors++; $display("FAIL reset_init rd1 addr=%0d got=%h exp=0000", a, rdata1); end
      checks++;
      if (rdata2 !== 16'h0000) begin errors++; $display("FAIL reset_init rd2 addr=%0d got=%h exp=0000", raddr2, rdata2); end
    end
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'($urandom_range(1, 16'hFFFF));
      step();
    end
    idle();
    for (int i = 1; i < 8; i++) begin
      raddr1 = 3'(i); #1;
      checks++;
      if (rdata1 !== model[i] || model[i] == 16'h0000) begin
        errors++; $display("FAIL preload rd1 addr=%0d got=%h exp=%h", i, rdata1, model[i]);
      end
    end
    rst = 1'b1;
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i); raddr2 = 3'(i); #1;
      checks++;
      if (rdata1 !== 16'h0000 || rdata2 !== 16'h0000) begin
        errors++; $display("FAIL reset_clear addr=%0d got=%h/%h exp=0000", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] old;
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr1 = 3'd3; raddr2 = 3'd0;
    old = model[3];
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rdata1 !== 16'hBEEF) begin errors++; $display("FAIL write_cycle rd1 got=%h exp=BEEF", rdata1); end
`else
    if (rdata1 !== old) begin errors++; $display("FAIL write_cycle rd1 got=%h exp=%h", rdata1, old); end
`endif
    step();
    idle();
    raddr1 = 3'd3; #1;
    checks++;
    if (rdata1 !== 16'hBEEF) begin errors++; $display("FAIL write_after rd1 got=%h exp=BEEF", rdata1); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0; raddr2 = 3'd0; #1;
    checks++;
    if (rdata1 !== 16'h0000 || rdata2 !== 16'h0000) begin
      errors++; $display("FAIL zero_during got=%h/%h exp=0000", rdata1, rdata2);
    end
    step();
    idle();
    raddr1 = 3'd0; raddr2 = 3'd0; #1;
    checks++;
    if (rdata1 !== 16'h0000 || rdata2 !== 16'h0000) begin
      errors++; $display("FAIL zero_after got=%h/%h exp=0000", rdata1, rdata2);
    end
  endtask

  task automatic test_reset_vs_write();
    we = 1'b1; waddr = 3'd5; wdata = 16'h7777;
    step();
    rst = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 16'h1234; raddr1 = 3'd5; raddr2 = 3'd5; #1;
    checks++;
    if (rdata1 !== 16'h7777) begin errors++; $display("FAIL rst_write_during rd1 got=%h exp=7777", rdata1); end
    step();
    idle();
    raddr1 = 3'd5; #1;
    checks++;
    if (rdata1 !== 16'h0000) begin errors++; $display("FAIL rst_write_after rd1 got=%h exp=0000", rdata1); end
    step();
    checks++;
    if (rdata1 !== 16'h0000) begin errors++; $display("FAIL rst_write_noreplay rd1 got=%h exp=0000", rdata1); end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
    step();
    we = 1'b1; waddr = 3'd6; wdata = 16'h5500;
    step();
    idle();
    raddr1 = 3'd2; raddr2 = 3'd6; #1;
    checks++;
    if (rdata1 !== 16'h00AA) begin errors++; $display("FAIL b2b rd1 got=%h exp=00AA", rdata1); end
    checks++;
    if (rdata2 !== 16'h5500) begin errors++; $display("FAIL b2b rd2 got=%h exp=5500", rdata2); end
    raddr1 = 3'd6; raddr2 = 3'd6; #1;
    checks++;
    if (rdata1 !== 16'h5500 || rdata2 !== 16'h5500) begin
      errors++; $display("FAIL same_addr got=%h/%h exp=5500", rdata1, rdata2);
    end
  endtask

  task automatic test_hold();
    we = 1'b1; waddr = 3'd7; wdata = 16'h8001;
    step();
    for (int i = 0; i < 20; i++) begin
      rst = 1'b0; we = 1'b0; waddr = 3'($urandom_range(0, 7)); wdata = 16'($urandom);
      raddr1 = 3'd7; raddr2 = 3'($urandom_range(0, 7)); #1;
      checks++;
      if (rdata1 !== 16'h8001) begin errors++; $display("FAIL hold r7 cyc=%0d got=%h exp=8001", i, rdata1); end
      checks++;
      if (rdata2 !== exp_rd(raddr2)) begin
        errors++; $display("FAIL hold rd2 cyc=%0d addr=%0d got=%h exp=%h", i, raddr2, rdata2, exp_rd(raddr2));
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 31) == 0);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 3'($urandom_range(0, 7));
      wdata  = 16'($urandom);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr2 = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (rdata1 !== exp_rd(raddr1)) begin
        errors++; $display("FAIL rand rd1 cyc=%0d addr=%0d got=%h exp=%h", i, raddr1, rdata1, exp_rd(raddr1));
      end
      checks++;
      if (rdata2 !== exp_rd(raddr2)) begin
        errors++; $display("FAIL rand rd2 cyc=%0d addr=%0d got=%h exp=%h", i, raddr2, rdata2, exp_rd(raddr2));
      end
      step();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    rst = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0; raddr1 = 3'd0; raddr2 = 3'd0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_reset_vs_write();
    test_back_to_back();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
